fifo_ctrl: RTL and testbench

//  Sequential control stage directly upstream of fifo_out: registers FIFO state code, data_count
//  and head/tail pointers from host wr_en/rd_en requests. state/data_count drive fifo_out (flags,
//  ack/err); we/re/waddr/raddr drive the FIFO register file. All bookkeeping for an 8-entry FIFO.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_ns.sv | 44 ++++
 rtl/fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the 8-entry FIFO bookkeeping path (fifo_ctrl and
//   the downstream fifo_out stage).
//
//   Contents:
//     DEPTH_DEF / ADDR_W_DEF  default geometry (DEPTH must equal 2**ADDR_W)
//     fifo_state_e            3-bit state codes INIT..RD_ERROR
//                             (codes 3'b110 / 3'b111 are never produced)
//     STATE_W                 width of the state code
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int STATE_W    = 3;

  // Encodings are fixed: fifo_out decodes these values directly into
  // ack/err/flag outputs.
  typedef enum logic [STATE_W-1:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } fifo_state_e;

endpackage

// File: rtl/fifo_ns.sv
// ---------------------------------------------------------------------------
// fifo_ns
//   Combinational next-state decoder for the FIFO control stage. Decides the
//   outcome of this cycle's host request from the current occupancy.
//
//   Parameters:
//     DEPTH   number of FIFO entries
//     ADDR_W  pointer width (data_count is ADDR_W+1 bits)
//
//   Ports:
//     wr_en       in   1         write request
//     rd_en       in   1         read request
//     data_count  in   ADDR_W+1  current registered occupancy
//     next_state  out  3         state to be registered on the next edge
// ---------------------------------------------------------------------------
module fifo_ns
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   data_count,
  output fifo_state_e       next_state
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  // Request semantics: wr_en / rd_en are single-cycle requests with no
  // back-pressure. Every sampled request is resolved in the same cycle to
  // exactly one outcome: accepted (WRITE/READ), refused (WR_ERROR/RD_ERROR)
  // or ignored (NO_OP when both or neither are asserted). The host learns
  // the outcome from the registered state one cycle later.
  always_comb begin
    next_state = NO_OP;
    if (wr_en && !rd_en) begin
      next_state = (data_count == FULL_COUNT) ? WR_ERROR : WRITE;
    end else if (!wr_en && rd_en) begin
      next_state = (data_count == '0) ? RD_ERROR : READ;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Sequential control stage feeding fifo_out and the FIFO register file.
//   Holds the state code, occupancy count and head/tail pointers, and
//   decodes the register-file strobes from the next state.
//
//   Optional feature macro: FIFO_CTRL_ALMOST_EN
//     defined   -> adds registered almost_full / almost_empty outputs
//     undefined -> those ports are absent; everything else identical
//
//   Parameters:
//     DEPTH   number of entries (must equal 2**ADDR_W)
//     ADDR_W  pointer width
//
//   Ports:
//     clk           in   1         rising-edge clock
//     reset         in   1         synchronous, active-high reset
//     wr_en         in   1         write request
//     rd_en         in   1         read request
//     state         out  3         registered state code
//     data_count    out  ADDR_W+1  registered occupancy 0..DEPTH
//     we            out  1         comb. write strobe (next state == WRITE)
//     waddr         out  ADDR_W    tail pointer (registered)
//     re            out  1         comb. read strobe (next state == READ)
//     raddr         out  ADDR_W    head pointer (registered)
//     almost_full   out  1         (macro only) data_count == DEPTH-1
//     almost_empty  out  1         (macro only) data_count == 1
// ---------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [STATE_W-1:0]  state,
  output logic [ADDR_W:0]     data_count,
  output logic                we,
  output logic [ADDR_W-1:0]   waddr,
  output logic                re,
  output logic [ADDR_W-1:0]   raddr
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic                almost_full,
  output logic                almost_empty
`endif
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [ADDR_W:0]   ALMOST_FULL_COUNT = (ADDR_W+1)'(DEPTH - 1);
`endif

  fifo_state_e      state_q;
  fifo_state_e      next_state;
  logic [ADDR_W:0]  count_q;
  logic [ADDR_W:0]  next_count;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [ADDR_W-1:0] next_head;
  logic [ADDR_W-1:0] next_tail;

  fifo_ns #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_count (count_q),
    .next_state (next_state)
  );

  // Pointer/count update implied by the decided outcome. The decoder never
  // returns WRITE at full or READ at empty, so the count stays in 0..DEPTH.
  // Pointers wrap naturally because DEPTH == 2**ADDR_W.
  always_comb begin
    next_count = count_q;
    next_head  = head_q;
    next_tail  = tail_q;
    case (next_state)
      WRITE: begin
        next_tail  = tail_q + PTR_ONE;
        next_count = count_q + CNT_ONE;
      end
      READ: begin
        next_head  = head_q + PTR_ONE;
        next_count = count_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
`ifdef FIFO_CTRL_ALMOST_EN
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
`endif
    end else begin
      state_q      <= next_state;
      count_q      <= next_count;
      head_q       <= next_head;
      tail_q       <= next_tail;
`ifdef FIFO_CTRL_ALMOST_EN
      // Flags track the count being registered on this same edge.
      almost_full  <= (next_count == ALMOST_FULL_COUNT);
      almost_empty <= (next_count == CNT_ONE);
`endif
    end
  end

  // Strobes act on the edge that completes the request. Reset masks them so
  // the register file is never touched while the pointers are being cleared.
  assign we = !reset && (next_state == WRITE);
  assign re = !reset && (next_state == READ);

  assign state      = state_q;
  assign data_count = count_q;
  assign waddr      = tail_q;
  assign raddr      = head_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//   Self-checking bench for fifo_ctrl. A behavioural occupancy/pointer model
//   predicts the registered outputs after every edge and the strobes within
//   every cycle; directed sequences add literal expectations on top.
//   Build with +define+FIFO_CTRL_ALMOST_EN to cover the almost flags.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int W      = 3 + (ADDR_W + 1) + ADDR_W + ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic                wr_en = 1'b0;
  logic                rd_en = 1'b0;
  logic [2:0]          state;
  logic [ADDR_W:0]     data_count;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic                re;
  logic [ADDR_W-1:0]   raddr;
`ifdef FIFO_CTRL_ALMOST_EN
  logic                almost_full;
  logic                almost_empty;
`endif

  fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .state      (state),
    .data_count (data_count),
    .we         (we),
    .waddr      (waddr),
    .re         (re),
    .raddr      (raddr)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // ---------------- behavioural model + scoreboard ----------------
  int m_count = 0;
  int m_head  = 0;
  int m_tail  = 0;
  int m_state = 0;
  bit m_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome of the current request at the coming edge, from occupancy rules.
  task automatic model_edge();
    if (reset) begin
      m_count = 0; m_head = 0; m_tail = 0; m_state = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (wr_en && !rd_en) begin
        if (m_count == DEPTH) m_state = 3;
        else begin
          m_state = 2;
          m_tail  = (m_tail + 1) % DEPTH;
          m_count = m_count + 1;
        end
      end else if (rd_en && !wr_en) begin
        if (m_count == 0) m_state = 5;
        else begin
          m_state = 4;
          m_head  = (m_head + 1) % DEPTH;
          m_count = m_count - 1;
        end
      end else begin
        m_state = 1;
      end
    end
    if (m_valid)
      exp_q.push_back({3'(m_state), 4'(m_count), 3'(m_tail), 3'(m_head)});
  endtask

  // Per-cycle comparison, performed mid-cycle away from the active edge.
  task automatic compare_outputs();
    logic [W-1:0] e;
    int exp_we, exp_re;
    exp_we = (!reset && m_valid && wr_en && !rd_en && m_count < DEPTH) ? 1 : 0;
    exp_re = (!reset && m_valid && rd_en && !wr_en && m_count > 0) ? 1 : 0;
    if (reset || m_valid) begin
      check("we", int'(we), exp_we);
      check("re", int'(re), exp_re);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",      int'(state),      int'(e[12:10]));
      check("data_count", int'(data_count), int'(e[9:6]));
      check("waddr",      int'(waddr),      int'(e[5:3]));
      check("raddr",      int'(raddr),      int'(e[2:0]));
      check("ptr_invariant", (int'(waddr) - int'(raddr) + DEPTH) % DEPTH,
            int'(data_count) % DEPTH);
`ifdef FIFO_CTRL_ALMOST_EN
      check("almost_full",  int'(almost_full),  (int'(e[9:6]) == DEPTH-1) ? 1 : 0);
      check("almost_empty", int'(almost_empty), (int'(e[9:6]) == 1) ? 1 : 0);
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic w, input logic rd);
    reset = r; wr_en = w; rd_en = rd;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    // 1: reset held with wr_en asserted
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("t1_state", int'(state), 0);
    check("t1_count", int'(data_count), 0);
    check("t1_we", int'(we), 0);
    check("t1_tail", int'(waddr), 0);
    check("t1_head", int'(raddr), 0);

    // 2: fill from empty
    for (int i = 0; i < 8; i++) begin
      check("t2_waddr", int'(waddr), i);
      cycle(1'b0, 1'b1, 1'b0);
      check("t2_state", int'(state), 2);
      check("t2_count", int'(data_count), i + 1);
    end
    // inputs still request a write while full
    check("t3_we_full", int'(we), 0);
    // 3: ninth write refused
    cycle(1'b0, 1'b1, 1'b0);
    check("t3_state", int'(state), 3);
    check("t3_count", int'(data_count), 8);
    check("t3_tail", int'(waddr), 0);

    // 4: read from empty, then fill and drain
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4_state", int'(state), 5);
    check("t4_count", int'(data_count), 0);
    writes(8);
    for (int i = 0; i < 8; i++) begin
      check("t4_raddr", int'(raddr), i);
      cycle(1'b0, 1'b0, 1'b1);
      check("t4_rstate", int'(state), 4);
    end
    check("t4_count_end", int'(data_count), 0);

    // 5: simultaneous request ignored
    cycle(1'b1, 1'b0, 1'b0);
    writes(3);
    cycle(1'b0, 1'b1, 1'b1);
    check("t5_state", int'(state), 1);
    check("t5_count", int'(data_count), 3);
    check("t5_we", int'(we), 0);
    check("t5_re", int'(re), 0);
    check("t5_tail", int'(waddr), 3);
    check("t5_head", int'(raddr), 0);

    // 6: pointer wrap, then mid-run reset
    cycle(1'b1, 1'b0, 1'b0);
    writes(6);
    reads(6);
    writes(4);
    check("t6_tail", int'(waddr), 2);
    check("t6_head", int'(raddr), 6);
    check("t6_count", int'(data_count), 4);
`ifdef FIFO_CTRL_ALMOST_EN
    writes(3);
    check("t6_almost_full", int'(almost_full), 1);
    reads(6);
    check("t6_almost_empty", int'(almost_empty), 1);
`endif
    cycle(1'b1, 1'b1, 1'b0);
    check("t6_rst_state", int'(state), 0);
    check("t6_rst_count", int'(data_count), 0);
    check("t6_rst_tail", int'(waddr), 0);
    check("t6_rst_head", int'(raddr), 0);

    // randomized phases with drifting write/read bias
    for (int blk = 0; blk < 10; blk++) begin
      pw = $urandom_range(15, 85);
      for (int i = 0; i < 40; i++) begin
        cycle(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 99) < pw),
              ($urandom_range(0, 99) < (100 - pw)));
      end
    end

    cycle(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
